// File: rtl/contador_pkg.sv
// Shared types and constants for the up/down counter with auto-repeat buttons.
package contador_pkg;

  typedef enum logic [1:0] {
    PASO_NINGUNO = 2'd0,
    PASO_ARRIBA  = 2'd1,
    PASO_ABAJO   = 2'd2
  } paso_t;

  localparam int WRAP_SATURA = 0;
  localparam int WRAP_VUELTA = 1;

  // Bits needed to hold values 0..valor, never less than one.
  function automatic int ancho_para(input int valor);
    int bits;
    bits = 1;
    while ((1 << bits) <= valor) bits++;
    return bits;
  endfunction

endpackage

// File: rtl/contador_ud_pulsador_rep.sv
// Per-button edge detector with hold-to-repeat; emits a one-cycle step request.
module pulsador_rep
  import contador_pkg::*;
#(
  parameter int REP_DLY = 0,
  parameter int REP_PER = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic btn,
  input  logic bloqueo,
  output logic paso_req
);

  localparam int CW = ancho_para((REP_DLY > REP_PER) ? REP_DLY : REP_PER);
  localparam logic [CW-1:0] DLY_C = CW'(REP_DLY);
  localparam logic [CW-1:0] PER_C = CW'(REP_PER);

  logic          hist_q, hist_d;
  logic [CW-1:0] hold_q, hold_d;
  logic          rep_q, rep_d;

  // The hold counter first runs to REP_DLY, then restarts and runs to REP_PER
  // between repeats; rep_q tells which of the two phases it is in.
  always_comb begin
    hist_d   = hist_q;
    hold_d   = hold_q;
    rep_d    = rep_q;
    paso_req = 1'b0;
    if (en) begin
      hist_d = btn;
      if (!btn || bloqueo) begin
        hold_d = '0;
        rep_d  = 1'b0;
      end else if (!hist_q) begin
        paso_req = 1'b1;
        hold_d   = (REP_DLY > 0) ? CW'(1) : '0;
        rep_d    = 1'b0;
      end else if (REP_DLY > 0) begin
        if (hold_q == (rep_q ? PER_C : DLY_C)) begin
          paso_req = 1'b1;
          hold_d   = CW'(1);
          rep_d    = 1'b1;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q <= 1'b0;
      hold_q <= '0;
      rep_q  <= 1'b0;
    end else begin
      hist_q <= hist_d;
      hold_q <= hold_d;
      rep_q  <= rep_d;
    end
  end

endmodule

// File: rtl/contador_ud.sv
// Up/down counter limited to 0..MAX, driven by two buttons with optional auto-repeat.
module contador_ud
  import contador_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MAX     = 8,
  parameter int WRAP    = 1,
  parameter int REP_DLY = 0,
  parameter int REP_PER = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       sb,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] cuenta,
  output logic             limite
);

  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX);

  logic             req_arriba, req_abajo;
  paso_t            paso;
  logic [WIDTH-1:0] cuenta_q, cuenta_d;
  logic             limite_q, limite_d;

  pulsador_rep #(.REP_DLY(REP_DLY), .REP_PER(REP_PER)) u_arriba (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .btn      (sb[1]),
    .bloqueo  (1'b0),
    .paso_req (req_arriba)
  );

  // Up wins: a held up button blocks and consumes any down press.
  pulsador_rep #(.REP_DLY(REP_DLY), .REP_PER(REP_PER)) u_abajo (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .btn      (sb[0]),
    .bloqueo  (sb[1]),
    .paso_req (req_abajo)
  );

  always_comb begin
    paso = PASO_NINGUNO;
    if (!load) begin
      if (req_arriba)     paso = PASO_ARRIBA;
      else if (req_abajo) paso = PASO_ABAJO;
    end
  end

  always_comb begin
    cuenta_d = cuenta_q;
    limite_d = 1'b0;
    if (load) begin
      cuenta_d = (load_val > MAX_C) ? MAX_C : load_val;
    end else begin
      case (paso)
        PASO_ARRIBA: begin
          if (cuenta_q >= MAX_C) begin
            limite_d = 1'b1;
            cuenta_d = (WRAP != WRAP_SATURA) ? '0 : MAX_C;
          end else begin
            cuenta_d = cuenta_q + 1'b1;
          end
        end
        PASO_ABAJO: begin
          if (cuenta_q == '0) begin
            limite_d = 1'b1;
            if (WRAP != WRAP_SATURA) cuenta_d = MAX_C;
          end else begin
            cuenta_d = cuenta_q - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cuenta_q <= '0;
      limite_q <= 1'b0;
    end else begin
      cuenta_q <= cuenta_d;
      limite_q <= limite_d;
    end
  end

  assign cuenta = cuenta_q;
  assign limite = limite_q;

endmodule

// File: tb/tb_contador_ud.sv
// Directed bench for contador_ud: three configurations driven by shared stimulus.
module tb_contador_ud;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [1:0] sb = 2'b00;
  logic       load = 1'b0;
  logic [3:0] load_val = 4'd0;

  logic [3:0] c0, c1, c2;
  logic       l0, l1, l2;

  int compared = 0;
  int mismatched = 0;
  int rep_steps[6] = '{1, 11, 15, 19, 23, 27};
  int expv;

  always #5 clk = ~clk;

  // Default configuration: wrap, no auto-repeat.
  contador_ud u_dut0 (
    .clk(clk), .rst(rst), .en(en), .sb(sb), .load(load),
    .load_val(load_val), .cuenta(c0), .limite(l0)
  );

  // Saturating configuration.
  contador_ud #(.WRAP(0)) u_dut1 (
    .clk(clk), .rst(rst), .en(en), .sb(sb), .load(load),
    .load_val(load_val), .cuenta(c1), .limite(l1)
  );

  // Auto-repeat configuration.
  contador_ud #(.REP_DLY(10), .REP_PER(4)) u_dut2 (
    .clk(clk), .rst(rst), .en(en), .sb(sb), .load(load),
    .load_val(load_val), .cuenta(c2), .limite(l2)
  );

  // Drive one cycle of inputs, then sample just after the rising edge.
  task automatic applyStimulus(input logic r, input logic e, input logic [1:0] s,
                               input logic l, input logic [3:0] lv);
    rst = r;
    en = e;
    sb = s;
    load = l;
    load_val = lv;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
      $error("[TB] check %s did not hold", tag);
    end
  endtask

  initial begin
    // Reset state
    applyStimulus(1, 0, 2'b00, 0, 0);
    checkOutput("rst_c0", c0, 0);
    checkOutput("rst_l0", l0, 0);
    checkOutput("rst_c1", c1, 0);
    checkOutput("rst_c2", c2, 0);

    // Nine up presses from 0: wrap vs saturate
    for (int i = 1; i <= 9; i++) begin
      applyStimulus(0, 1, 2'b10, 0, 0);
      checkOutput($sformatf("up%0d_c0", i), c0, (i == 9) ? 0 : i);
      checkOutput($sformatf("up%0d_l0", i), l0, (i == 9) ? 1 : 0);
      checkOutput($sformatf("up%0d_c1", i), c1, (i == 9) ? 8 : i);
      checkOutput($sformatf("up%0d_l1", i), l1, (i == 9) ? 1 : 0);
      checkOutput($sformatf("up%0d_c2", i), c2, (i == 9) ? 0 : i);
      applyStimulus(0, 1, 2'b00, 0, 0);
      checkOutput($sformatf("rel%0d_l0", i), l0, 0);
    end

    // Down presses at 0
    applyStimulus(1, 1, 2'b00, 0, 0);
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(0, 1, 2'b01, 0, 0);
      checkOutput($sformatf("dn%0d_c1", i), c1, 0);
      checkOutput($sformatf("dn%0d_l1", i), l1, 1);
      checkOutput($sformatf("dn%0d_c0", i), c0, 9 - i);
      checkOutput($sformatf("dn%0d_l0", i), l0, (i == 1) ? 1 : 0);
      applyStimulus(0, 1, 2'b00, 0, 0);
    end

    // Simultaneous presses from 5
    applyStimulus(0, 1, 2'b00, 1, 5);
    checkOutput("ld5_c0", c0, 5);
    applyStimulus(0, 1, 2'b11, 0, 0);
    checkOutput("both_c0", c0, 6);
    checkOutput("both_c1", c1, 6);
    checkOutput("both_l0", l0, 0);
    applyStimulus(0, 1, 2'b11, 0, 0);
    checkOutput("bothheld_c0", c0, 6);
    applyStimulus(0, 1, 2'b00, 0, 0);
    applyStimulus(0, 1, 2'b01, 0, 0);
    checkOutput("dnafter_c0", c0, 5);
    applyStimulus(0, 1, 2'b00, 0, 0);

    // Load clamps to MAX and works with en low; en low freezes presses
    applyStimulus(0, 0, 2'b00, 1, 13);
    checkOutput("ld13_c0", c0, 8);
    checkOutput("ld13_c1", c1, 8);
    checkOutput("ld13_c2", c2, 8);
    applyStimulus(0, 0, 2'b10, 0, 0);
    checkOutput("dis_up_c0", c0, 8);
    applyStimulus(0, 0, 2'b01, 0, 0);
    checkOutput("dis_dn_c0", c0, 8);
    checkOutput("dis_dn_l0", l0, 0);
    applyStimulus(0, 1, 2'b00, 0, 0);
    checkOutput("reen_c0", c0, 8);

    // Load beats a press in the same cycle and consumes it
    applyStimulus(0, 1, 2'b10, 1, 3);
    checkOutput("ldpress_c0", c0, 3);
    applyStimulus(0, 1, 2'b10, 0, 0);
    checkOutput("ldheld_c0", c0, 3);
    applyStimulus(0, 1, 2'b00, 0, 0);

    // Auto-repeat: hold up for 30 cycles
    applyStimulus(1, 1, 2'b00, 0, 0);
    for (int k = 1; k <= 30; k++) begin
      applyStimulus(0, 1, 2'b10, 0, 0);
      expv = 0;
      foreach (rep_steps[j]) if (rep_steps[j] <= k) expv++;
      checkOutput($sformatf("rep%0d_c2", k), c2, expv[7:0]);
      checkOutput($sformatf("rep%0d_l2", k), l2, 0);
    end
    checkOutput("rep_c0", c0, 1);

    // Reset during repeat, button held across it
    applyStimulus(0, 1, 2'b00, 0, 0);
    applyStimulus(1, 1, 2'b00, 0, 0);
    for (int k = 1; k <= 20; k++) applyStimulus(0, 1, 2'b10, 0, 0);
    checkOutput("mid_c2", c2, 4);
    applyStimulus(1, 1, 2'b10, 0, 0);
    checkOutput("midrst_c2", c2, 0);
    checkOutput("midrst_l2", l2, 0);
    applyStimulus(0, 1, 2'b10, 0, 0);
    checkOutput("postrst_c2", c2, 1);
    checkOutput("postrst_c0", c0, 1);
    for (int k = 1; k <= 9; k++) applyStimulus(0, 1, 2'b10, 0, 0);
    checkOutput("postrst_dly_c2", c2, 1);
    applyStimulus(0, 1, 2'b10, 0, 0);
    checkOutput("postrst_rep_c2", c2, 2);
    applyStimulus(0, 1, 2'b00, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
